// File: rtl/demux1x2_7bits_seq_if.sv
// demux1x2_7bits_seq_if: word-in handshake and lane-pair-out handshake bundle
interface demux1x2_7bits_seq_if #(parameter int p_w = 7);
  logic [p_w-1:0] ent;
  logic           ent_valid;
  logic           ent_ready;
  logic           sel_mode;
  logic           sel;
  logic [p_w-1:0] out0;
  logic [p_w-1:0] out1;
  logic           out_valid;
  logic           out_ack;
  logic           err_overwrite;
  logic           lane;
  modport master (
    output ent, ent_valid, sel_mode, sel, out_ack,
    input  ent_ready, out0, out1, out_valid, err_overwrite, lane
  );
  modport slave (
    input  ent, ent_valid, sel_mode, sel, out_ack,
    output ent_ready, out0, out1, out_valid, err_overwrite, lane
  );
endinterface

// File: rtl/demux1x2_7bits_seq.sv
// demux1x2_7bits_seq: distributes a 7-bit word stream into two registered lanes, presented as a pair
module demux1x2_7bits_seq (
  input logic clk,
  input logic rst,
  demux1x2_7bits_seq_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, HALF0, HALF1, FULL} state_t;
  state_t state, state_n;
  logic [6:0] out0_q, out1_q;
  logic err_q, f0, f1, acc, tgt, ovw, nf0, nf1;
  always_comb begin
    f0 = state == HALF0 || state == FULL;
    f1 = state == HALF1 || state == FULL;
    acc = bus.ent_valid && state != FULL;
    tgt = bus.sel_mode ? bus.sel : f0;
    ovw = acc && (tgt ? f1 : f0);
    nf0 = f0 || (acc && !tgt);
    nf1 = f1 || (acc && tgt);
    state_n = (state == FULL) ? (bus.out_ack ? EMPTY : FULL) :
              (nf0 && nf1) ? FULL : nf0 ? HALF0 : nf1 ? HALF1 : EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      out0_q <= '0;
      out1_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= ovw;
      if (acc && !tgt) out0_q <= bus.ent;
      if (acc && tgt) out1_q <= bus.ent;
    end
  end
  assign bus.ent_ready = state != FULL;
  assign bus.out_valid = state == FULL;
  assign bus.out0 = out0_q;
  assign bus.out1 = out1_q;
  assign bus.err_overwrite = err_q;
  assign bus.lane = f0;
endmodule

// File: tb/tb_demux1x2_7bits_seq.sv
// tb_demux1x2_7bits_seq: directed scenarios plus randomized traffic against a lane/flag model
module tb_demux1x2_7bits_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  logic [6:0] m_o [2];
  logic m_f [2];
  logic m_v, m_e;
  demux1x2_7bits_seq_if bus ();
  demux1x2_7bits_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // advance one clock, updating the model from the inputs held across the edge
  task automatic step();
    int k;
    if (rst) begin
      m_o[0] = 0; m_o[1] = 0; m_f[0] = 0; m_f[1] = 0; m_v = 0; m_e = 0;
    end else begin
      m_e = 0;
      if (m_v && bus.out_ack) begin
        m_v = 0; m_f[0] = 0; m_f[1] = 0;
      end else if (bus.ent_valid && !m_v) begin
        k = bus.sel_mode ? int'(bus.sel) : (m_f[0] ? 1 : 0);
        if (bus.sel_mode && m_f[k]) m_e = 1;
        m_o[k] = bus.ent;
        m_f[k] = 1;
        if (m_f[0] && m_f[1]) m_v = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.ent_valid = 0; bus.out_ack = 0; bus.sel_mode = 0; bus.sel = 0; bus.ent = 0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1; step(); rst = 0;
  endtask
  task automatic test_reset();
    rst = 1; idle(); step(); step(); rst = 0;
    total++; if (bus.out0 !== 7'h00 || bus.out1 !== 7'h00) $display("FAIL reset_outs out0=%h out1=%h want 00/00", bus.out0, bus.out1); else passed++;
    total++; if (bus.out_valid !== 1'b0 || bus.err_overwrite !== 1'b0) $display("FAIL reset_flags valid=%b err=%b want 0/0", bus.out_valid, bus.err_overwrite); else passed++;
    total++; if (bus.lane !== 1'b0 || bus.ent_ready !== 1'b1) $display("FAIL reset_lane lane=%b ready=%b want 0/1", bus.lane, bus.ent_ready); else passed++;
  endtask
  task automatic test_auto();
    bus.ent = 7'h3F; bus.ent_valid = 1; step();
    total++; if (bus.out0 !== 7'h3F || bus.lane !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL auto_first out0=%h lane=%b valid=%b want 3f/1/0", bus.out0, bus.lane, bus.out_valid); else passed++;
    bus.ent = 7'h06; step();
    total++; if (bus.out1 !== 7'h06 || bus.out_valid !== 1'b1) $display("FAIL auto_pair out1=%h valid=%b want 06/1", bus.out1, bus.out_valid); else passed++;
    total++; if (bus.ent_ready !== 1'b0) $display("FAIL auto_ready ready=%b want 0", bus.ent_ready); else passed++;
  endtask
  task automatic test_backpressure();
    bus.ent = 7'h5B; bus.ent_valid = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (bus.out0 !== 7'h3F || bus.out1 !== 7'h06 || bus.out_valid !== 1'b1) $display("FAIL bp_hold%0d out0=%h out1=%h valid=%b want 3f/06/1", i, bus.out0, bus.out1, bus.out_valid); else passed++;
    end
    bus.out_ack = 1; step(); bus.out_ack = 0;
    total++; if (bus.out_valid !== 1'b0 || bus.out0 !== 7'h3F || bus.out1 !== 7'h06 || bus.ent_ready !== 1'b1) $display("FAIL bp_ack valid=%b out0=%h out1=%h ready=%b want 0/3f/06/1", bus.out_valid, bus.out0, bus.out1, bus.ent_ready); else passed++;
    step();
    total++; if (bus.out0 !== 7'h5B || bus.lane !== 1'b1) $display("FAIL bp_land out0=%h lane=%b want 5b/1", bus.out0, bus.lane); else passed++;
    idle();
  endtask
  task automatic test_overwrite();
    do_reset();
    bus.sel_mode = 1; bus.sel = 1; bus.ent = 7'h4F; bus.ent_valid = 1; step();
    total++; if (bus.out1 !== 7'h4F || bus.err_overwrite !== 1'b0) $display("FAIL ow_first out1=%h err=%b want 4f/0", bus.out1, bus.err_overwrite); else passed++;
    bus.ent = 7'h66; step();
    total++; if (bus.out1 !== 7'h66 || bus.err_overwrite !== 1'b1 || bus.lane !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL ow_hit out1=%h err=%b lane=%b valid=%b want 66/1/0/0", bus.out1, bus.err_overwrite, bus.lane, bus.out_valid); else passed++;
    bus.ent_valid = 0; step();
    total++; if (bus.err_overwrite !== 1'b0) $display("FAIL ow_pulse err=%b want 0", bus.err_overwrite); else passed++;
    bus.sel = 0; bus.ent = 7'h6D; bus.ent_valid = 1; step();
    total++; if (bus.out_valid !== 1'b1 || bus.out0 !== 7'h6D || bus.out1 !== 7'h66) $display("FAIL ow_pair valid=%b out0=%h out1=%h want 1/6d/66", bus.out_valid, bus.out0, bus.out1); else passed++;
    idle(); bus.out_ack = 1; step(); bus.out_ack = 0;
    total++; if (bus.out_valid !== 1'b0 || bus.lane !== 1'b0) $display("FAIL ow_ack valid=%b lane=%b want 0/0", bus.out_valid, bus.lane); else passed++;
  endtask
  task automatic test_mode_switch();
    bus.ent = 7'h7D; bus.ent_valid = 1; step();
    bus.sel_mode = 1; bus.sel = 0; bus.ent = 7'h07; step();
    total++; if (bus.out0 !== 7'h07 || bus.err_overwrite !== 1'b1 || bus.lane !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL switch out0=%h err=%b lane=%b valid=%b want 07/1/1/0", bus.out0, bus.err_overwrite, bus.lane, bus.out_valid); else passed++;
    idle();
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.ent = 7'h7F; bus.ent_valid = 1; step();
    total++; if (bus.out0 !== 7'h7F) $display("FAIL rmid_load out0=%h want 7f", bus.out0); else passed++;
    rst = 1; step(); rst = 0; bus.ent_valid = 0;
    total++; if (bus.out0 !== 7'h00 || bus.out1 !== 7'h00 || bus.out_valid !== 1'b0 || bus.lane !== 1'b0 || bus.ent_ready !== 1'b1) $display("FAIL rmid out0=%h out1=%h valid=%b lane=%b ready=%b want 00/00/0/0/1", bus.out0, bus.out1, bus.out_valid, bus.lane, bus.ent_ready); else passed++;
  endtask
  task automatic test_stray_ack();
    idle(); bus.out_ack = 1; step();
    total++; if (bus.out_valid !== 1'b0 || bus.lane !== 1'b0 || bus.out0 !== 7'h00) $display("FAIL stray_empty valid=%b lane=%b out0=%h want 0/0/00", bus.out_valid, bus.lane, bus.out0); else passed++;
    bus.out_ack = 0; bus.ent = 7'h12; bus.ent_valid = 1; step();
    bus.ent_valid = 0; bus.out_ack = 1; step(); bus.out_ack = 0;
    total++; if (bus.out_valid !== 1'b0 || bus.lane !== 1'b1 || bus.out0 !== 7'h12) $display("FAIL stray_half valid=%b lane=%b out0=%h want 0/1/12", bus.out_valid, bus.lane, bus.out0); else passed++;
    bus.ent = 7'h34; bus.ent_valid = 1; step(); bus.ent_valid = 0;
    total++; if (bus.out_valid !== 1'b1 || bus.out1 !== 7'h34) $display("FAIL stray_pair valid=%b out1=%h want 1/34", bus.out_valid, bus.out1); else passed++;
  endtask
  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.ent = 7'($urandom);
      bus.ent_valid = 1'($urandom_range(0, 3) != 0);
      bus.sel_mode = 1'($urandom_range(0, 2) == 0);
      bus.sel = 1'($urandom);
      bus.out_ack = 1'($urandom_range(0, 2) == 0);
      step();
      total++;
      if (bus.out0 !== m_o[0] || bus.out1 !== m_o[1] || bus.out_valid !== m_v || bus.err_overwrite !== m_e || bus.lane !== m_f[0] || bus.ent_ready !== !m_v) begin
        if (bad < 10) $display("FAIL rand%0d out0=%h out1=%h valid=%b err=%b lane=%b ready=%b want %h/%h/%b/%b/%b/%b", i, bus.out0, bus.out1, bus.out_valid, bus.err_overwrite, bus.lane, bus.ent_ready, m_o[0], m_o[1], m_v, m_e, m_f[0], !m_v);
        bad++;
      end else passed++;
    end
    rst = 0; idle();
  endtask
  initial begin
    idle();
    test_reset();
    test_auto();
    test_backpressure();
    test_overwrite();
    test_mode_switch();
    test_reset_mid();
    test_stray_ack();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/demux1x2_7bits_seq.md
# demux1x2_7bits_seq

Sequential 1-to-2 demultiplexer for 7-bit words: the inverse of the 2:1 7-bit lane selector. It takes a stream of 7-bit words (typically seven-segment patterns) from one shared bus through a valid/ready handshake. It distributes the words into two registered output lanes and presents the completed pair to downstream display logic with its own valid/ack handshake. It sits between the single-bus pattern source and the two-digit display registers.

## Interface
- p_w, 7, word width of input and of each output lane
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- ent  input  p_w  input word
- ent_valid  input  1  ent carries a word this cycle
- ent_ready  output  1  block can accept a word this cycle
- sel_mode  input  1  0 = auto-alternate lanes (0 then 1); 1 = explicit lane via sel
- sel  input  1  target lane when sel_mode=1 (0 → out0, 1 → out1); ignored when sel_mode=0
- out0  output  p_w  lane 0 register
- out1  output  p_w  lane 1 register
- out_valid  output  1  both lanes loaded since last ack; pair available
- out_ack  input  1  downstream consumes pair (meaningful only while out_valid=1)
- err_overwrite  output  1  one-cycle pulse: explicit-mode write hit an already-loaded lane
- lane  output  1  lane the next auto-mode word will go to (= f0)

## Operation
- Internal flags f0, f1: lane 0 / lane 1 loaded since last pair ack.
- Accept = ent_valid & ent_ready; ent_ready = ~out_valid (combinational from the out_valid register).
- Target lane on accept: sel_mode=0 → (f0 ? 1 : 0); sel_mode=1 → sel. sel_mode and sel are sampled per accept; switching mode mid-pair is legal, and flags carry over.
- On accept to lane k: out_k ← ent, f_k ← 1. In explicit mode, if f_k was already 1: out_k is still overwritten, f flags unchanged, and err_overwrite pulses high the next cycle. Auto mode never overwrites.
- When f0 & f1 become 1: out_valid ← 1 on the same edge as the completing accept's flag update.
- While out_valid=1: no accepts. out0/out1 are frozen.
- out_valid=1 & out_ack=1 at an edge: out_valid ← 0, f0 ← 0, f1 ← 0. out0/out1 keep their values; they are not cleared.
- out_ack while out_valid=0: ignored.
- States, derived from flags: EMPTY (f0=f1=0), HALF0 (f0 only), HALF1 (f1 only, explicit mode only), FULL (out_valid=1).
- Transitions:
  - EMPTY → HALF0/HALF1 on accept.
  - HALFx → FULL on accept to the other lane.
  - HALFx → HALFx on explicit overwrite of the same lane.
  - FULL → EMPTY on out_ack.

## Timing
- Reset (rst=1 at an edge) forces: out0=0, out1=0, out_valid=0, err_overwrite=0, f0=f1=0, lane=0. ent_ready therefore reads 1 from the first post-reset cycle.
- Reset mid-pair discards the partial pair. Reset has priority over simultaneous accept/ack.
- Write latency: word visible on out_k one cycle after the accept edge.
- Pair latency: out_valid high one cycle after the second accept. Minimum pair period is 3 cycles (accept, accept, ack) in the auto stream.
- Simultaneous out_ack and ent_valid in FULL: the ack is taken; ent is not accepted (ent_ready=0). ent is accepted at the next edge into lane 0 in auto mode.
- err_overwrite is exactly one cycle wide per offending accept. Back-to-back offending accepts give back-to-back pulses.
- Upstream holds ent stable while ent_valid=1 & ent_ready=0. The block samples ent only on accept.

## Test plan
- Reset then auto mode:
  - Stimulus: ent=7'h3F valid 1 cycle, then ent=7'h06 valid 1 cycle, out_ack low.
  - Required: out0=7'h3F after the first edge; out1=7'h06 and out_valid=1 after the second; ent_ready=0 while FULL.
- Backpressure:
  - Stimulus: in FULL, drive ent=7'h5B valid for 3 cycles, with out_ack asserted on the 3rd.
  - Required: out0/out1 unchanged for all 3 cycles; out_valid=0 after the ack edge; 7'h5B lands in out0 one edge later.
- Explicit overwrite:
  - Stimulus: sel_mode=1, sel=1, ent=7'h4F; then sel=1, ent=7'h66.
  - Required: out1=7'h66, err_overwrite high 1 cycle, f0=0, out_valid=0.
  - Follow-up: sel=0, ent=7'h6D → out_valid=1.
- Mode switch mid-pair:
  - Stimulus: auto-accept 7'h7D into lane 0, then sel_mode=1, sel=0, ent=7'h07.
  - Required: overwrite of out0 with 7'h07, err pulse, lane=1, no pair.
- Reset mid-pair:
  - Stimulus: one word accepted (out0=7'h7F), then rst=1 for 1 cycle.
  - Required: out0=0, out_valid=0, lane=0, ent_ready=1 in the next cycle.
- Stray ack:
  - Stimulus: out_ack=1 while EMPTY/HALF0.
  - Required: no flag or output change.
